// File: rtl/hopfield_pkg.sv
// Shared types and defaults for the Hopfield spike decoder.
// Holds FSM encoding, default sizes and winner index width.
package hopfield_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_N     = 7;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  localparam int IDX_W = $clog2(DEF_N);

endpackage

// File: rtl/spike_edge_counter.sv
// Per-neuron rising-edge counter with saturation.
// Ports: clk, reset, i_spike, i_clr, i_en -> o_cnt.
module spike_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_spike,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic             w_sat;

  assign w_edge = i_spike & ~r_prev;
  assign w_sat  = &r_cnt;
  assign o_cnt  = r_cnt;

  // Previous level is tracked in every state so a line
  // already high at window start does not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_spike;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && w_edge && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts per-neuron spike edges over a
// window, thresholds them into a pattern and finds the winner.
// Ports: clk, reset, start, window_len, threshold, spikes in;
// busy, valid, pattern, winner, any_spike out.
// Macro SPIKE_DECODER_COUNTS_EN adds counts_flat output.
module spike_rate_decoder
  import hopfield_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic [N-1:0]     spikes,
  output logic             busy,
  output logic             valid,
  output logic [N-1:0]     pattern,
  output logic [IDX_W-1:0] winner,
`ifdef SPIKE_DECODER_COUNTS_EN
  output logic             any_spike,
  output logic [N*CNT_W-1:0] counts_flat
`else
  output logic             any_spike
`endif
);

  localparam logic [WIN_W-1:0] SETTLE_LAST =
    WIN_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [WIN_W-1:0] r_cyc;
  logic [WIN_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_thr;

  logic             w_accept;
  logic             w_count_en;
  logic             w_done;

  logic [CNT_W-1:0] w_cnt [N];
  logic [N*CNT_W-1:0] w_cnt_flat;
  logic [N-1:0]     w_pat;
  logic [CNT_W-1:0] w_best_cnt;
  logic [IDX_W-1:0] w_best_idx;
  logic             w_any;

  // Counters
  for (genvar g = 0; g < N; g++) begin : g_cnt
    spike_edge_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_spike (spikes[g]),
      .i_clr   (w_accept),
      .i_en    (w_count_en),
      .o_cnt   (w_cnt[g])
    );
    assign w_cnt_flat[g*CNT_W +: CNT_W] = w_cnt[g];
    assign w_pat[g] = (w_cnt[g] >= r_thr);
  end

  assign w_any = |w_cnt_flat;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best_cnt = w_cnt[0];
    w_best_idx = '0;
    for (int i = 1; i < N; i++) begin
      if (w_cnt[i] > w_best_cnt) begin
        w_best_cnt = w_cnt[i];
        w_best_idx = IDX_W'(i);
      end
    end
  end

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_count_en = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (SETTLE > 0) ? ST_SETTLE : ST_COUNT;
        end
      end
      ST_SETTLE: begin
        if (r_cyc == SETTLE_LAST) begin
          w_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_count_en = 1'b1;
        if (r_cyc == r_win_len - WIN_W'(1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Cycle counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc <= '0;
    end else if (w_next != r_state) begin
      r_cyc <= '0;
    end else if (r_state == ST_SETTLE ||
                 r_state == ST_COUNT) begin
      r_cyc <= r_cyc + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_len <= WIN_W'(1);
      r_thr     <= '0;
    end else if (w_accept) begin
      r_win_len <= (window_len == '0) ? WIN_W'(1)
                                      : window_len;
      r_thr     <= threshold;
    end
  end

  // Busy covers the valid cycle; a fresh accept wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else if (w_accept) begin
      busy <= 1'b1;
    end else if (valid) begin
      busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else begin
      valid <= w_done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern   <= '0;
      winner    <= '0;
      any_spike <= 1'b0;
    end else if (w_done) begin
      pattern   <= w_pat;
      winner    <= w_best_idx;
      any_spike <= w_any;
    end
  end

`ifdef SPIKE_DECODER_COUNTS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counts_flat <= '0;
    end else if (w_done) begin
      counts_flat <= w_cnt_flat;
    end
  end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder.
// Uses CNT_W=4 so saturation is reachable quickly.
module tb_spike_rate_decoder;

  localparam int N  = 7;
  localparam int CW = 4;
  localparam int WW = 16;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic [CW-1:0] threshold = '0;
  logic [N-1:0]  spikes = '0;
  logic          busy;
  logic          valid;
  logic [N-1:0]  pattern;
  logic [2:0]    winner;
  logic          any_spike;

  int n_chk = 0;
  int n_fail = 0;
  int nv;

  spike_rate_decoder #(
    .N      (N),
    .CNT_W  (CW),
    .WIN_W  (WW),
    .SETTLE (S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .window_len (window_len),
    .threshold  (threshold),
    .spikes     (spikes),
    .busy       (busy),
    .valid      (valid),
    .pattern    (pattern),
    .winner     (winner),
    .any_spike  (any_spike)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [N-1:0] sp);
    spikes = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic go(input logic [WW-1:0] wl,
                    input logic [CW-1:0] th,
                    input logic [N-1:0]  sp);
    window_len = wl;
    threshold  = th;
    start      = 1'b1;
    step(sp);
    start      = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic         v,
                         input logic [N-1:0] p,
                         input logic [2:0]   w,
                         input logic         a);
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_pattern"}, 32'(pattern), 32'(p));
    chk({tag, "_winner"}, 32'(winner), 32'(w));
    chk({tag, "_any"}, 32'(any_spike), 32'(a));
  endtask

  initial begin
    // Reset state
    step('0);
    step('0);
    chk_out("rst", 1'b0, 7'h00, 3'd0, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step('0);
    step('0);

    // Basic recall: neurons 0,2 give 5 edges each
    go(16'd20, 4'd3, '0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 24; j++) begin
      step((j >= 4 && j <= 20 && j % 4 == 0) ?
           7'b0000101 : 7'b0);
    end
    chk("t1_early", 32'(valid), 32'd0);
    step('0);
    chk_out("t1", 1'b1, 7'b0000101, 3'd0, 1'b1);
    chk("t1_busy_v", 32'(busy), 32'd1);
    step('0);
    chk("t1_vdrop", 32'(valid), 32'd0);
    chk("t1_bdrop", 32'(busy), 32'd0);
    chk("t1_hold", 32'(pattern), 32'h05);

    // Held-high line never counts
    step(7'h08);
    go(16'd10, 4'd1, 7'h08);
    for (int j = 0; j < 14; j++) step(7'h08);
    step(7'h08);
    chk_out("t2a", 1'b1, 7'h00, 3'd0, 1'b0);
    step(7'h08);

    // One drop/rise mid-window counts once
    go(16'd10, 4'd1, 7'h08);
    for (int j = 0; j < 14; j++) begin
      step((j == 7) ? 7'h00 : 7'h08);
    end
    step(7'h08);
    chk_out("t2b", 1'b1, 7'h08, 3'd3, 1'b1);
    step('0);

    // Saturation and tie: 50 edges on 5 and 6
    go(16'd100, 4'd15, '0);
    for (int j = 0; j < 104; j++) begin
      step((j % 2 == 1) ? 7'h60 : 7'h00);
    end
    step('0);
    chk_out("t3", 1'b1, 7'h60, 3'd5, 1'b1);
    step('0);

    // window_len=0 acts as 1; threshold 0; no spikes
    go(16'd0, 4'd0, '0);
    for (int j = 0; j < 5; j++) step('0);
    chk("t4_early", 32'(valid), 32'd0);
    step('0);
    chk_out("t4", 1'b1, 7'h7F, 3'd0, 1'b0);
    step('0);

    // start re-pulsed while busy is ignored
    go(16'd5, 4'd1, '0);
    nv = 0;
    for (int j = 0; j < 20; j++) begin
      start = (j == 2 || j == 3);
      step('0);
      if (valid) nv++;
    end
    start = 1'b0;
    chk("t5_nvalid", 32'(nv), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);

    // start held: valid every S+W+2 = 9 cycles
    window_len = 16'd3;
    threshold  = 4'd0;
    start      = 1'b1;
    step('0);
    for (int j = 0; j < 27; j++) begin
      step('0);
      chk($sformatf("t6_v%0d", j), 32'(valid),
          32'(j == 7 || j == 16 || j == 25));
      chk($sformatf("t6_b%0d", j), 32'(busy), 32'd1);
    end
    start = 1'b0;
    for (int j = 0; j < 12; j++) step('0);
    chk("t6_pat", 32'(pattern), 32'h7F);

    // Reset mid-COUNT
    go(16'd20, 4'd1, '0);
    for (int j = 0; j < 14; j++) begin
      step((j % 2 == 1) ? 7'h02 : 7'h00);
    end
    #2;
    reset = 1'b1;
    #1;
    chk_out("t7_rst", 1'b0, 7'h00, 3'd0, 1'b0);
    chk("t7_busy", 32'(busy), 32'd0);
    step('0);
    reset = 1'b0;
    nv = 0;
    for (int j = 0; j < 25; j++) begin
      step((j % 2 == 1) ? 7'h02 : 7'h00);
      if (valid) nv++;
    end
    chk("t7_novalid", 32'(nv), 32'd0);
    step('0);
    go(16'd5, 4'd1, '0);
    for (int j = 0; j < 9; j++) begin
      step((j == 6) ? 7'h10 : 7'h00);
    end
    step('0);
    chk_out("t7_after", 1'b1, 7'h10, 3'd4, 1'b1);
    step('0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
